// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: clk50 is divided down to the pixel clock, h/v timing fields
// are reprogrammable through a shadow bank that is committed at the frame boundary.
module vga_timing_gen #(
  parameter int CLKDIV  = 2,
  parameter int W       = 12,
  parameter int HACTIVE = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VACTIVE = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0
) (
  input  logic         clk50,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_wdata,
  input  logic         irq_ack,
  output logic         VGA_CLK,
  output logic         VGA_HS,
  output logic         VGA_VS,
  output logic         VGA_BLANK_n,
  output logic         VGA_SYNC_n,
  output logic [W-1:0] VGA_HCOUNT,
  output logic [W-1:0] VGA_VCOUNT,
  output logic         pix_stb,
  output logic         line_start,
  output logic         frame_start,
  output logic         vblank_irq
);

  localparam int DW = $clog2(CLKDIV);
  localparam int TW = W + 2;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV / 2);

  localparam logic [2:0] F_HACT = 3'd0;
  localparam logic [2:0] F_HFP  = 3'd1;
  localparam logic [2:0] F_HSYN = 3'd2;
  localparam logic [2:0] F_HBP  = 3'd3;
  localparam logic [2:0] F_VACT = 3'd4;
  localparam logic [2:0] F_VFP  = 3'd5;
  localparam logic [2:0] F_VSYN = 3'd6;
  localparam logic [2:0] F_VBP  = 3'd7;

  localparam logic [7:0][W-1:0] FIELD_INIT = {
    W'(VBP), W'(VSYNC), W'(VFP), W'(VACTIVE),
    W'(HBP), W'(HSYNC), W'(HFP), W'(HACTIVE)
  };

  function automatic logic [TW-1:0] ext(input logic [W-1:0] v);
    return TW'(v);
  endfunction

  // Sync is asserted for cnt in [active+fp, active+fp+sync); sums kept at TW bits.
  function automatic logic sync_level(input logic [W-1:0] cnt, input logic [W-1:0] act,
                                      input logic [W-1:0] fp, input logic [W-1:0] sw,
                                      input logic pol);
    logic [TW-1:0] first_c;
    logic [TW-1:0] end_c;
    first_c = ext(act) + ext(fp);
    end_c   = first_c + ext(sw);
    if ((ext(cnt) >= first_c) && (ext(cnt) < end_c))
      return pol;
    else
      return !pol;
  endfunction

  logic [DW-1:0]         div;
  logic [W-1:0]          hcount;
  logic [W-1:0]          vcount;
  logic [7:0][W-1:0]     act_f;
  logic [7:0][W-1:0]     shd_f;
  logic                  pending;

  logic [W-1:0]          hactive;
  logic [W-1:0]          vactive;
  logic [TW-1:0]         htot;
  logic [TW-1:0]         vtot;
  logic                  h_last;
  logic                  v_last;
  logic                  h_wrap;
  logic                  v_wrap;
  logic                  irq_set;

  assign hactive = act_f[F_HACT];
  assign vactive = act_f[F_VACT];
  assign htot    = ext(act_f[F_HACT]) + ext(act_f[F_HFP]) + ext(act_f[F_HSYN]) + ext(act_f[F_HBP]);
  assign vtot    = ext(act_f[F_VACT]) + ext(act_f[F_VFP]) + ext(act_f[F_VSYN]) + ext(act_f[F_VBP]);

  assign pix_stb = (div == DIV_LAST);
  assign VGA_CLK = (div >= DIV_HALF);
  assign h_last  = (ext(hcount) == htot - TW'(1));
  assign v_last  = (ext(vcount) == vtot - TW'(1));
  assign h_wrap  = pix_stb && h_last;
  assign v_wrap  = h_wrap && v_last;
  // Flag rises together with line_start on the line where vcount becomes vactive.
  assign irq_set = h_wrap && !v_last && ((vcount + W'(1)) == vactive);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      div <= '0;
    else if (pix_stb)
      div <= '0;
    else
      div <= div + DW'(1);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_stb) begin
      hcount <= h_last ? '0 : hcount + W'(1);
      if (h_last)
        vcount <= v_last ? '0 : vcount + W'(1);
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (irq_set)
        vblank_irq <= 1'b1;
      else if (irq_ack)
        vblank_irq <= 1'b0;
    end
  end

  // A write in the commit cycle lands in shadow only and keeps pending set for the next frame.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      shd_f   <= FIELD_INIT;
      act_f   <= FIELD_INIT;
      pending <= 1'b0;
    end else begin
      if (cfg_we)
        shd_f[cfg_addr] <= cfg_wdata;
      if (v_wrap && pending)
        act_f <= shd_f;
      if (cfg_we)
        pending <= 1'b1;
      else if (v_wrap)
        pending <= 1'b0;
    end
  end

  assign VGA_HS      = sync_level(hcount, act_f[F_HACT], act_f[F_HFP], act_f[F_HSYN], HS_POL);
  assign VGA_VS      = sync_level(vcount, act_f[F_VACT], act_f[F_VFP], act_f[F_VSYN], VS_POL);
  assign VGA_BLANK_n = (hcount < hactive) && (vcount < vactive);
  assign VGA_SYNC_n  = 1'b1;
  assign VGA_HCOUNT  = hcount;
  assign VGA_VCOUNT  = vcount;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised, runtime-reprogrammable VGA raster timing generator. It produces the pixel clock, HS/VS, blanking, pixel coordinates, line/frame strobes and a sticky vertical-blank interrupt. All timing comes from a single fast clock through an integer pixel-clock divider. Timing fields are written through a shadow-register port and committed atomically at the frame boundary. It sits between the system clock domain and the sprite/framebuffer pipeline, which consumes `VGA_HCOUNT`/`VGA_VCOUNT` and the strobes.

## Interface
- `CLKDIV`, 2: clk50 cycles per pixel; must be ≥2 (even values give a 50% duty `VGA_CLK`).
- `W`, 12: width of timing fields and pixel counters.
- `HACTIVE`/`HFP`/`HSYNC`/`HBP`, 640/16/96/48: reset horizontal timing, in pixels.
- `VACTIVE`/`VFP`/`VSYNC`/`VBP`, 480/10/2/33: reset vertical timing, in lines.
- `HS_POL`/`VS_POL`, 0/0: sync asserted level (0 = active-low).
- `clk50  in  1`: sole clock; all flops on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `cfg_we  in  1`: shadow-register write strobe.
- `cfg_addr  in  3`: 0 hactive, 1 hfp, 2 hsync, 3 hbp, 4 vactive, 5 vfp, 6 vsync, 7 vbp.
- `cfg_wdata  in  W`: write data; 0 is illegal for every field, and behaviour with a 0 field is undefined.
- `irq_ack  in  1`: clears `vblank_irq`.
- `VGA_CLK  out  1`: pixel clock.
- `VGA_HS`, `VGA_VS`, `VGA_BLANK_n`, `VGA_SYNC_n  out  1`: sync, blank and sync-on-green outputs; `VGA_SYNC_n` is tied to 1.
- `VGA_HCOUNT`, `VGA_VCOUNT  out  W`: current pixel column and line.
- `pix_stb  out  1`: one-clk50 pulse on the last cycle of each pixel.
- `line_start`, `frame_start  out  1`: one-clk50 pulses.
- `vblank_irq  out  1`: sticky interrupt flag.

## Operation
- **Divider.** `div` counts 0..CLKDIV-1 and wraps. `pix_stb = (div == CLKDIV-1)`. `VGA_CLK = (div >= CLKDIV/2)`.
- **Horizontal counter.** `hcount` advances only on `pix_stb`. It wraps to 0 after `htot-1`, where `htot = hactive+hfp+hsync+hbp`. Totals are computed at W+2 bits.
- **Vertical counter.** `vcount` advances on `pix_stb` when `hcount == htot-1`. It wraps after `vtot-1`.
- **Horizontal regions, in order from 0:** active, front porch, sync, back porch. `VGA_HS` is at `HS_POL` when `hactive+hfp ≤ hcount < hactive+hfp+hsync`, else at `!HS_POL`.
- **Vertical sync.** `VGA_VS` follows the same rule with the v fields, evaluated on `vcount`.
- **Blanking.** `VGA_BLANK_n = (hcount < hactive) && (vcount < vactive)`.
- **Coordinates.** `VGA_HCOUNT = hcount` and `VGA_VCOUNT = vcount` (pixel units, not clk50 units).
- **Sync/blank decode.** Combinational from the registered counters and the active fields.
- **Strobes.**
  - `line_start` is registered. It pulses the cycle after a `pix_stb` that wraps `hcount` to 0, so it is high during the first clk50 cycle of pixel 0.
  - `frame_start` pulses the same way when `vcount` also wraps.
- **Interrupt.** `vblank_irq` is set on the cycle `vcount` becomes `vactive` (that is, with `line_start`). It is cleared by `irq_ack`. If set and ack coincide, set wins.
- **Config writes.**
  - `cfg_we` writes `shadow[cfg_addr]` and sets `pending`.
  - Commit happens on the `pix_stb` that wraps both counters. If `pending` is set, active fields ← shadow and `pending` is cleared.
  - A write in the commit cycle is not included. It stays in shadow with `pending` still set, so it commits at the next frame.
  - Active fields never change mid-frame, so counters can never be out of range.
- **Reset values.**
  - Counters, `div` and `pending` = 0.
  - Active and shadow fields = parameters.
  - Outputs under reset: `VGA_CLK` 0, `VGA_HS` `!HS_POL`, `VGA_VS` `!VS_POL`, `VGA_BLANK_n` 1, `VGA_SYNC_n` 1, `pix_stb` 0, `line_start` 0, `frame_start` 0, `vblank_irq` 0.

## Timing
- Pixel period is CLKDIV clk50 cycles. Line is `htot·CLKDIV` cycles. Frame is `htot·vtot·CLKDIV` cycles.
- Sync, blank and coordinates change on the clk50 edge after `pix_stb`, i.e. aligned to the falling edge of `VGA_CLK`. Downstream latches pixel data on the rising edge of `VGA_CLK`.
- `line_start`/`frame_start`/`vblank_irq` set have one clk50 cycle of latency after the counter update edge.
- A config write takes effect at the first frame wrap strictly after the write cycle, with 0 frames of latency beyond that wrap.
- Reset deasserted mid-line restarts at pixel (0,0) with `div = 0` and no strobe on the first cycle.

## Test plan
- **Defaults, CLKDIV=2, reset released at t=0:**
  - `VGA_CLK` toggles every cycle.
  - `VGA_HS` is low for clk50 cycles 1312..1503 of each 1600-cycle line.
  - `VGA_BLANK_n` is high for cycles 0..1279 of lines 0..479.
  - `VGA_VS` is low on lines 490–491.
  - `frame_start` recurs every 840000 cycles.
- **CLKDIV=4:**
  - `VGA_CLK` is 0,0,1,1 per pixel.
  - `pix_stb` is every 4th cycle.
  - Line is 3200 cycles.
  - `VGA_HCOUNT` steps once per 4 cycles.
- **Mid-frame write of hactive=320 at line 100:**
  - The current frame keeps 800-pixel lines.
  - After `frame_start`, lines are 480 pixels and `VGA_BLANK_n` is high for pixels 0..319.
- **Write landing exactly on the commit `pix_stb`:**
  - It is not applied this frame.
  - It is applied at the following `frame_start`.
- **Interrupt:**
  - `vblank_irq` rises with `line_start` at `vcount` 480 and holds until `irq_ack`.
  - `irq_ack` asserted in the set cycle leaves the flag 1.
- **Reset asserted at `hcount` 700, `vcount` 300:**
  - All outputs take their reset values asynchronously.
  - After release, the counters start from 0 and active fields are back at parameters, with `pending` cleared.
